// File: rtl/mem_arb.sv
// Two-port SRAM arbiter: instruction fetch and data ports share one single-port SRAM.
// Data wins contested cycles until the instruction port has waited STARVE_MAX times.
module mem_arb #(
   parameter int STARVE_MAX = 3,
   parameter int AW         = 14
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_req,
   input  logic [AW+1:0] i_adr,
   output logic          i_gnt,
   output logic          i_rvld,
   output logic [31:0]   i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_be,
   input  logic [AW+1:0] d_adr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvld,
   output logic [31:0]   d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [3:0]    m_be,
   output logic [AW-1:0] m_a,
   output logic [31:0]   m_wd,
   input  logic [31:0]   m_rd,
   output logic [15:0]   conflict_cnt
);

   localparam int SW = (STARVE_MAX > 3) ? $clog2(STARVE_MAX + 1) : 2;

   typedef enum logic [1:0] {
      RIDLE = 2'd0,
      RINS  = 2'd1,
      RDAT  = 2'd2
   } resp_t;

   resp_t         resp_r;
   resp_t         resp_nxt_s;
   logic [SW-1:0] starve_r;
   logic [15:0]   conflict_r;
   logic          contest_s;
   logic          i_win_s;
   logic          d_win_s;
   logic          unused_s;

   assign unused_s     = ^{i_adr[1:0], d_adr[1:0]};
   assign contest_s    = i_req & d_req;
   assign conflict_cnt = conflict_r;
   assign i_rdata      = m_rd;
   assign d_rdata      = m_rd;
   assign i_gnt        = i_win_s;
   assign d_gnt        = d_win_s;

   // Same-cycle grant decision; reset masks every grant.
   always_comb begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
      if (rstn) begin
         i_win_s = 1'b0;
         d_win_s = 1'b0;
      end else if (contest_s) begin
         if (starve_r == SW'(STARVE_MAX)) begin
            i_win_s = 1'b1;
         end else begin
            d_win_s = 1'b1;
         end
      end else begin
         i_win_s = i_req;
         d_win_s = d_req;
      end
   end

   // SRAM command mux; address and write data are don't-care when idle.
   always_comb begin
      m_en = 1'b0;
      m_we = 1'b0;
      m_be = 4'h0;
      m_a  = i_adr[AW+1:2];
      m_wd = d_wdata;
      if (i_win_s) begin
         m_en = 1'b1;
         m_be = 4'hF;
      end else if (d_win_s) begin
         m_en = 1'b1;
         m_we = d_we;
         m_be = d_we ? d_be : 4'hF;
         m_a  = d_adr[AW+1:2];
      end else begin
         m_en = 1'b0;
      end
   end

   // Starvation counter: counts data wins over a waiting instruction fetch.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         starve_r <= {SW{1'b0}};
      end else if (i_win_s) begin
         starve_r <= {SW{1'b0}};
      end else if (contest_s && d_win_s) begin
         starve_r <= starve_r + {{(SW-1){1'b0}}, 1'b1};
      end else begin
         starve_r <= starve_r;
      end
   end

   // Saturating count of contested cycles.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         conflict_r <= 16'h0000;
      end else if (contest_s && (conflict_r != 16'hFFFF)) begin
         conflict_r <= conflict_r + 16'h0001;
      end else begin
         conflict_r <= conflict_r;
      end
   end

   // Response FSM state register; reset drops any outstanding read.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         resp_r <= RIDLE;
      end else begin
         resp_r <= resp_nxt_s;
      end
   end

   // Response FSM next state: follows this cycle's grant, independent of the current state.
   always_comb begin
      resp_nxt_s = RIDLE;
      if (i_win_s) begin
         resp_nxt_s = RINS;
      end else if (d_win_s && !d_we) begin
         resp_nxt_s = RDAT;
      end else begin
         resp_nxt_s = RIDLE;
      end
   end

   // Response FSM outputs: read data valid one cycle after the grant.
   always_comb begin
      i_rvld = 1'b0;
      d_rvld = 1'b0;
      case (resp_r)
         RINS:    i_rvld = 1'b1;
         RDAT:    d_rvld = 1'b1;
         default: begin
            i_rvld = 1'b0;
            d_rvld = 1'b0;
         end
      endcase
   end

endmodule
